ap_ctrl_perf_monitor: RTL

Synthesizable, multi-channel performance monitor for HLS `ap_ctrl_chain` blocks. It watches the start/ready/done/continue handshakes and the pipelined-loop iteration enables of up to `NUM_CH` kernels. It supports up to `MAX_INFLIGHT` overlapping (rewound/pipelined) transactions per channel, and produces per-channel transaction, latency, interval, stall and iteration statistics. These are read out through a registered select port. It sits beside the DUT in the hardware dataflow path, where a file-dumping simulation monitor is unavailable.

---
 rtl/ap_mon_pkg.sv | 43 ++++
 rtl/ap_mon_channel.sv | 142 ++++++++++++++
 rtl/ap_ctrl_perf_monitor.sv | 109 ++++++++++
 3 files changed

// File: rtl/ap_mon_pkg.sv
// Shared types and helpers for the ap_ctrl_chain performance monitor.
// Statistic fields are carried at STAT_W and trimmed to CNT_W at the read port.
package ap_mon_pkg;

  localparam int STAT_W = 64;

  typedef enum logic [2:0] {
    SEL_DONE     = 3'd0,
    SEL_START    = 3'd1,
    SEL_LAST_LAT = 3'd2,
    SEL_MIN_LAT  = 3'd3,
    SEL_MAX_LAT  = 3'd4,
    SEL_INTERVAL = 3'd5,
    SEL_STALL    = 3'd6,
    SEL_ITER     = 3'd7
  } rd_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [STAT_W-1:0] txn_done;
    logic [STAT_W-1:0] txn_start;
    logic [STAT_W-1:0] last_lat;
    logic [STAT_W-1:0] min_lat;
    logic [STAT_W-1:0] max_lat;
    logic [STAT_W-1:0] last_interval;
    logic [STAT_W-1:0] stall_cyc;
    logic [STAT_W-1:0] iter_inflight;
  } chan_stats_t;

  // Increment that sticks at all-ones of a counter `width` bits wide.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                input int unsigned width);
    logic [STAT_W-1:0] ceiling;
    ceiling = {STAT_W{1'b1}} >> (STAT_W - width);
    return (value >= ceiling) ? ceiling : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/ap_mon_channel.sv
// One monitored ap_ctrl_chain channel: start-timestamp FIFO, IDLE/ACTIVE/STALL
// tracking and saturating statistics. `hold` freezes every register.
module ap_mon_channel
  import ap_mon_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int LAT_W        = 24,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [LAT_W-1:0]  now,
  input  logic              start_acc,
  input  logic              done_acc,
  input  logic              done_blocked,
  input  logic              iter_start_en,
  input  logic              iter_end_en,
  output chan_stats_t       stats,
  output logic              err
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int OCC_W = $clog2(MAX_INFLIGHT + 1);

  logic [LAT_W-1:0] ts_mem [MAX_INFLIGHT];

  ch_state_e        state_reg, state_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_inc, rd_ptr_inc;
  logic             err_reg, seen_start_reg;
  logic [CNT_W-1:0] txn_start_reg, txn_done_reg, stall_cyc_reg;
  logic [CNT_W-1:0] iter_issued_reg, iter_retired_reg, iter_inflight;
  logic [LAT_W-1:0] last_lat_reg, min_lat_reg, max_lat_reg;
  logic [LAT_W-1:0] last_interval_reg, prev_start_ts_reg, lat;

  logic empty, full, do_pop, do_bypass, do_push, completes, set_err;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(STAT_W'(v), CNT_W));
  endfunction

  // A start and a completion in the same cycle on an empty FIFO bypass it with
  // zero latency; on a non-empty FIFO the pop reads the old head.
  always_comb begin
    empty      = (occ_reg == '0);
    full       = (occ_reg == OCC_W'(MAX_INFLIGHT));
    do_pop     = done_acc & ~empty;
    do_bypass  = done_acc & empty & start_acc;
    do_push    = start_acc & ~do_bypass & (~full | do_pop);
    completes  = do_pop | do_bypass;
    set_err    = (done_acc & empty & ~start_acc) | (start_acc & full & ~done_acc);
    wr_ptr_inc = (wr_ptr_reg == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    rd_ptr_inc = (rd_ptr_reg == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    lat        = '0;
    if (do_pop) begin
      lat = now - ts_mem[rd_ptr_reg];
    end
    occ_next = occ_reg;
    if (do_push && !do_pop) begin
      occ_next = occ_reg + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      occ_next = occ_reg - OCC_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    if (occ_next == '0) begin
      state_next = IDLE;
    end else if (done_blocked) begin
      state_next = STALL;
    end else begin
      state_next = ACTIVE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !hold && do_push) begin
      ts_mem[wr_ptr_reg] <= now;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      occ_reg           <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      err_reg           <= 1'b0;
      seen_start_reg    <= 1'b0;
      txn_start_reg     <= '0;
      txn_done_reg      <= '0;
      stall_cyc_reg     <= '0;
      iter_issued_reg   <= '0;
      iter_retired_reg  <= '0;
      last_lat_reg      <= '0;
      min_lat_reg       <= '1;
      max_lat_reg       <= '0;
      last_interval_reg <= '0;
      prev_start_ts_reg <= '0;
    end else if (!hold) begin
      state_reg <= state_next;
      occ_reg   <= occ_next;
      if (do_push) wr_ptr_reg <= wr_ptr_inc;
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      if (set_err) err_reg <= 1'b1;
      if (start_acc) begin
        txn_start_reg     <= inc(txn_start_reg);
        prev_start_ts_reg <= now;
        seen_start_reg    <= 1'b1;
        if (seen_start_reg) last_interval_reg <= now - prev_start_ts_reg;
      end
      if (completes) begin
        last_lat_reg <= lat;
        if (lat < min_lat_reg) min_lat_reg <= lat;
        if (lat > max_lat_reg) max_lat_reg <= lat;
        txn_done_reg <= inc(txn_done_reg);
      end
      if (state_reg == STALL) stall_cyc_reg    <= inc(stall_cyc_reg);
      if (iter_start_en)      iter_issued_reg  <= inc(iter_issued_reg);
      if (iter_end_en)        iter_retired_reg <= inc(iter_retired_reg);
    end
  end

  assign iter_inflight = iter_issued_reg - iter_retired_reg;

  always_comb begin
    stats               = '0;
    stats.txn_done      = STAT_W'(txn_done_reg);
    stats.txn_start     = STAT_W'(txn_start_reg);
    stats.last_lat      = STAT_W'(last_lat_reg);
    stats.min_lat       = STAT_W'(min_lat_reg);
    stats.max_lat       = STAT_W'(max_lat_reg);
    stats.last_interval = STAT_W'(last_interval_reg);
    stats.stall_cyc     = STAT_W'(stall_cyc_reg);
    stats.iter_inflight = STAT_W'(iter_inflight);
  end

  assign err = err_reg;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl_chain performance monitor: shared timebase, freeze
// control and a registered statistic read port over NUM_CH channel monitors.
module ap_ctrl_perf_monitor
  import ap_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int LAT_W        = 24,
  parameter int MAX_INFLIGHT = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_start_en,
  input  logic [NUM_CH-1:0] iter_end_en,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] err,
  output logic              frozen
);

  logic [LAT_W-1:0]  now_reg;
  logic              frozen_reg;
  logic [CNT_W-1:0]  rd_data_reg;
  logic              rd_valid_reg;
  chan_stats_t       stats [NUM_CH];
  chan_stats_t       sel_stats;
  logic [STAT_W-1:0] sel_value;
  logic              unused_stat_bits;

  // The timebase keeps running while frozen so post-freeze reads stay coherent.
  always_ff @(posedge clock) begin
    if (reset) begin
      now_reg    <= '0;
      frozen_reg <= 1'b0;
    end else begin
      now_reg    <= now_reg + LAT_W'(1);
      frozen_reg <= frozen_reg | finish;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ap_mon_channel #(
        .CNT_W        (CNT_W),
        .LAT_W        (LAT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
      ) u_channel (
        .clock         (clock),
        .reset         (reset),
        .hold          (frozen_reg),
        .now           (now_reg),
        .start_acc     (ap_start[gi] & ap_ready[gi]),
        .done_acc      (ap_done[gi] & ap_continue[gi]),
        .done_blocked  (ap_done[gi] & ~ap_continue[gi]),
        .iter_start_en (iter_start_en[gi]),
        .iter_end_en   (iter_end_en[gi]),
        .stats         (stats[gi]),
        .err           (err[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_stats = '0;
    sel_value = '0;
    if (int'(rd_ch) < NUM_CH) begin
      sel_stats = stats[rd_ch];
      case (rd_sel_e'(rd_sel))
        SEL_DONE:     sel_value = sel_stats.txn_done;
        SEL_START:    sel_value = sel_stats.txn_start;
        SEL_LAST_LAT: sel_value = sel_stats.last_lat;
        SEL_MIN_LAT:  sel_value = sel_stats.min_lat;
        SEL_MAX_LAT:  sel_value = sel_stats.max_lat;
        SEL_INTERVAL: sel_value = sel_stats.last_interval;
        SEL_STALL:    sel_value = sel_stats.stall_cyc;
        SEL_ITER:     sel_value = sel_stats.iter_inflight;
        default:      sel_value = '0;
      endcase
    end
  end

  // Bits above CNT_W are always zero; fold them away explicitly.
  assign unused_stat_bits = ^(sel_value >> CNT_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= sel_value[CNT_W-1:0];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign frozen   = frozen_reg;

endmodule
